// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
// Holds the sequencer state encoding and the saturating counter helper.
package ifetch_pkg;

   localparam int          ADDR_W_DEF    = 8;
   localparam int          DATA_W_DEF    = 32;
   localparam logic [31:0] HALT_WORD_DEF = 32'h0000_0000;
   localparam int          COUNT_W       = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } state_e;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      if (c == {COUNT_W{1'b1}}) begin
         return c;
      end
      return c + COUNT_W'(1);
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory read port plus the valid/ready
// handshake towards decode. master = fetch sequencer, slave = memory/decode.
interface instr_fetch_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_rdata;
   logic              if_valid;
   logic              if_ready;
   logic [DATA_W-1:0] if_instr;
   logic [ADDR_W-1:0] if_pc;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc
   );
endinterface

// File: rtl/instr_fetch_ctrl_pc_reg.sv
// Program counter: load has priority over increment; increment wraps
// naturally at 2^ADDR_W. Also usable by the multicycle datapath.
module instr_fetch_ctrl_pc_reg #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_addr;
      end else if (inc) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= PC_RESET;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, captures words from the combinational
// instruction memory and offers them to decode over valid/ready.
module instr_fetch_ctrl
   import ifetch_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                DATA_W    = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] PC_RESET  = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic                 step,
   input  logic                 redirect_valid,
   input  logic [ADDR_W-1:0]    redirect_addr,
   instr_fetch_ctrl_if.master   bus,
   output logic                 halted,
   output logic [COUNT_W-1:0]   instr_count
);
   state_e              state_q, state_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]   ifpc_q, ifpc_d;
   logic                halted_q, halted_d;
   logic [COUNT_W-1:0]  cnt_q, cnt_d;

   logic                pc_load;
   logic                pc_inc;
   logic                capture;
   logic                accept;
   logic [ADDR_W-1:0]   pc;

   instr_fetch_ctrl_pc_reg #(
      .ADDR_W   (ADDR_W),
      .PC_RESET (PC_RESET)
   ) u_pc (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (pc_load),
      .load_addr (redirect_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   assign accept = valid_q && bus.if_ready;

   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      instr_d  = instr_q;
      ifpc_d   = ifpc_q;
      halted_d = halted_q;
      cnt_d    = cnt_q;
      pc_load  = 1'b0;
      pc_inc   = 1'b0;
      capture  = 1'b0;

      // An accept coinciding with a redirect still counts as delivered.
      if (accept) begin
         cnt_d = sat_inc(cnt_q);
      end

      if (redirect_valid) begin
         pc_load  = 1'b1;
         valid_d  = 1'b0;
         halted_d = 1'b0;
         state_d  = run ? FETCH : IDLE;
      end else begin
         unique case (state_q)
            IDLE:  if (run || step) state_d = FETCH;
            FETCH: capture = 1'b1;
            HOLD: begin
               if (accept) begin
                  if (run) begin
                     capture = 1'b1;
                  end else begin
                     valid_d = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
         endcase

         if (capture) begin
            if (bus.imem_rdata == HALT_WORD) begin
               state_d  = HALT;
               halted_d = 1'b1;
               valid_d  = 1'b0;
            end else begin
               instr_d = bus.imem_rdata;
               ifpc_d  = pc;
               valid_d = 1'b1;
               pc_inc  = 1'b1;
               state_d = HOLD;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         ifpc_q   <= '0;
         halted_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         ifpc_q   <= ifpc_d;
         halted_q <= halted_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.imem_addr = pc;
   assign bus.if_valid  = valid_q;
   assign bus.if_instr  = instr_q;
   assign bus.if_pc     = ifpc_q;
   assign halted        = halted_q;
   assign instr_count   = cnt_q;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus randomized
// programs checked against a queue of expected (pc, instr) deliveries.
module tb_instr_fetch_ctrl;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam logic [31:0] W0 = 32'h200100CA;
   localparam logic [31:0] W1 = 32'h00210820;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run = 1'b0;
   logic step = 1'b0;
   logic redirect_valid = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic halted;
   logic [15:0] instr_count;
   logic [DW-1:0] mem [256];

   int n_cmp = 0;
   int n_err = 0;

   instr_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   instr_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .run            (run),
      .step           (step),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .bus            (bus),
      .halted         (halted),
      .instr_count    (instr_count)
   );

   assign bus.imem_rdata = mem[bus.imem_addr];

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic load_prog();
      clear_mem();
      mem[0] = W0;
      for (int i = 1; i <= 4; i++) mem[i] = W1;
   endtask

   task automatic do_reset();
      run = 1'b0; step = 1'b0; redirect_valid = 1'b0; bus.if_ready = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.if_ready = 1'b0; clear_mem();
      @(posedge clk);
      #1;
      n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.if_valid); end
      n_cmp++; if (bus.if_instr !== '0) begin n_err++; $display("FAIL rst_instr: got %h want 0", bus.if_instr); end
      n_cmp++; if (bus.if_pc !== '0) begin n_err++; $display("FAIL rst_pc: got %h want 0", bus.if_pc); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", halted); end
      n_cmp++; if (instr_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", instr_count); end
      n_cmp++; if (bus.imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h want 00", bus.imem_addr); end
      #4 rst_n = 1'b1;
   endtask

   task automatic test_free_run();
      logic [31:0] exp_w;
      load_prog();
      do_reset();
      bus.if_ready = 1'b1; run = 1'b1;
      tick();
      n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL fr_latency: valid got %b want 0 one cycle after run", bus.if_valid); end
      tick();
      for (int i = 0; i < 5; i++) begin
         exp_w = (i == 0) ? W0 : W1;
         n_cmp++; if (bus.if_valid !== 1'b1) begin n_err++; $display("FAIL fr_valid%0d: got %b want 1", i, bus.if_valid); end
         n_cmp++; if (bus.if_instr !== exp_w) begin n_err++; $display("FAIL fr_instr%0d: got %h want %h", i, bus.if_instr, exp_w); end
         n_cmp++; if (bus.if_pc !== AW'(i)) begin n_err++; $display("FAIL fr_pc%0d: got %h want %h", i, bus.if_pc, i); end
         tick();
      end
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL fr_halted: got %b want 1", halted); end
      n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL fr_valid_end: got %b want 0", bus.if_valid); end
      n_cmp++; if (instr_count !== 16'd5) begin n_err++; $display("FAIL fr_count: got %0d want 5", instr_count); end
      n_cmp++; if (bus.imem_addr !== 8'h05) begin n_err++; $display("FAIL fr_addr: got %h want 05", bus.imem_addr); end
      // run/step are ignored while halted
      step = 1'b1; tick(); step = 1'b0; tick();
      n_cmp++; if (halted !== 1'b1 || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL fr_halt_sticky: halted %b valid %b want 1 0", halted, bus.if_valid); end
      run = 1'b0;
   endtask

   task automatic test_step();
      load_prog();
      do_reset();
      bus.if_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL st_fetch%0d: valid got %b want 0", k, bus.if_valid); end
         tick();
         n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== AW'(k)) begin n_err++; $display("FAIL st_deliver%0d: valid %b pc %h want 1 %h", k, bus.if_valid, bus.if_pc, k); end
         for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (bus.if_valid !== 1'b0) begin n_err++; $display("FAIL st_idle%0d_%0d: valid got %b want 0", k, c, bus.if_valid); end
         end
      end
      n_cmp++; if (instr_count !== 16'd3) begin n_err++; $display("FAIL st_count: got %0d want 3", instr_count); end
      n_cmp++; if (bus.imem_addr !== 8'h03) begin n_err++; $display("FAIL st_addr: got %h want 03", bus.imem_addr); end
   endtask

   task automatic test_stall();
      load_prog();
      do_reset();
      bus.if_ready = 1'b1; run = 1'b1;
      tick(); tick(); tick();
      bus.if_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_instr !== W1 || bus.if_pc !== 8'h01) begin
            n_err++; $display("FAIL sl_hold%0d: valid %b instr %h pc %h want 1 %h 01", c, bus.if_valid, bus.if_instr, bus.if_pc, W1);
         end
         n_cmp++; if (bus.imem_addr !== 8'h02) begin n_err++; $display("FAIL sl_addr%0d: got %h want 02", c, bus.imem_addr); end
         tick();
      end
      bus.if_ready = 1'b1;
      tick();
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h02) begin n_err++; $display("FAIL sl_release: valid %b pc %h want 1 02", bus.if_valid, bus.if_pc); end
      run = 1'b0;
      tick();
      n_cmp++; if (instr_count !== 16'd3 || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL sl_count: count %0d valid %b want 3 0", instr_count, bus.if_valid); end
   endtask

   task automatic test_redirect();
      load_prog();
      do_reset();
      bus.if_ready = 1'b0; run = 1'b1;
      tick(); tick();
      redirect_valid = 1'b1; redirect_addr = 8'h03;
      tick();
      redirect_valid = 1'b0;
      n_cmp++; if (bus.if_valid !== 1'b0 || instr_count !== 16'd0) begin n_err++; $display("FAIL rd_flush: valid %b count %0d want 0 0", bus.if_valid, instr_count); end
      n_cmp++; if (bus.imem_addr !== 8'h03) begin n_err++; $display("FAIL rd_addr: got %h want 03", bus.imem_addr); end
      tick();
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h03) begin n_err++; $display("FAIL rd_target: valid %b pc %h want 1 03", bus.if_valid, bus.if_pc); end
      bus.if_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'h03;
      tick();
      redirect_valid = 1'b0;
      n_cmp++; if (instr_count !== 16'd1 || bus.if_valid !== 1'b0) begin n_err++; $display("FAIL rd_accept: count %0d valid %b want 1 0", instr_count, bus.if_valid); end
      tick();
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h03) begin n_err++; $display("FAIL rd_target2: valid %b pc %h want 1 03", bus.if_valid, bus.if_pc); end
      run = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      clear_mem();
      mem[8'hFE] = 32'hAAAA_0001;
      mem[8'hFF] = 32'hBBBB_0002;
      mem[8'h00] = 32'hCCCC_0003;
      do_reset();
      redirect_valid = 1'b1; redirect_addr = 8'hFE; run = 1'b1; bus.if_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_cmp++; if (bus.if_pc !== 8'hFE || bus.if_instr !== 32'hAAAA_0001) begin n_err++; $display("FAIL wr_fe: pc %h instr %h want fe aaaa0001", bus.if_pc, bus.if_instr); end
      tick();
      n_cmp++; if (bus.if_pc !== 8'hFF || bus.if_instr !== 32'hBBBB_0002) begin n_err++; $display("FAIL wr_ff: pc %h instr %h want ff bbbb0002", bus.if_pc, bus.if_instr); end
      tick();
      n_cmp++; if (bus.if_pc !== 8'h00 || bus.if_instr !== 32'hCCCC_0003) begin n_err++; $display("FAIL wr_00: pc %h instr %h want 00 cccc0003", bus.if_pc, bus.if_instr); end
      tick();
      n_cmp++; if (halted !== 1'b1 || instr_count !== 16'd3) begin n_err++; $display("FAIL wr_halt: halted %b count %0d want 1 3", halted, instr_count); end
      run = 1'b0;
   endtask

   task automatic test_async_reset_and_halt_exit();
      load_prog();
      do_reset();
      bus.if_ready = 1'b0; run = 1'b1;
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.if_valid !== 1'b0 || bus.if_instr !== '0 || bus.if_pc !== '0) begin
         n_err++; $display("FAIL ar_bus: valid %b instr %h pc %h want 0 0 0", bus.if_valid, bus.if_instr, bus.if_pc);
      end
      n_cmp++; if (bus.imem_addr !== 8'h00 || halted !== 1'b0 || instr_count !== 16'd0) begin
         n_err++; $display("FAIL ar_ctrl: addr %h halted %b count %0d want 00 0 0", bus.imem_addr, halted, instr_count);
      end
      run = 1'b0;
      #2 rst_n = 1'b1;
      clear_mem();
      mem[0] = 32'h1234_5678;
      tick();
      run = 1'b1; bus.if_ready = 1'b1;
      tick(); tick(); tick();
      n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL ha_enter: halted got %b want 1", halted); end
      redirect_valid = 1'b1; redirect_addr = 8'h00;
      tick();
      redirect_valid = 1'b0;
      n_cmp++; if (halted !== 1'b0 || bus.imem_addr !== 8'h00) begin n_err++; $display("FAIL ha_exit: halted %b addr %h want 0 00", halted, bus.imem_addr); end
      tick();
      n_cmp++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 8'h00 || bus.if_instr !== 32'h1234_5678) begin
         n_err++; $display("FAIL ha_resume: valid %b pc %h instr %h want 1 00 12345678", bus.if_valid, bus.if_pc, bus.if_instr);
      end
      run = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [AW-1:0] exp_pc [$];
      logic [DW-1:0] exp_ins [$];
      logic [AW-1:0] start;
      logic [DW-1:0] w;
      int len;
      int cycles;
      for (int it = 0; it < 12; it++) begin
         clear_mem();
         exp_pc.delete(); exp_ins.delete();
         start = AW'($urandom_range(0, 255));
         len = $urandom_range(1, 12);
         for (int j = 0; j < len; j++) begin
            w = $urandom;
            if (w == '0) w = 32'h1;
            mem[AW'(start + AW'(j))] = w;
            exp_pc.push_back(AW'(start + AW'(j)));
            exp_ins.push_back(w);
         end
         do_reset();
         redirect_valid = 1'b1; redirect_addr = start; run = 1'b1;
         tick();
         redirect_valid = 1'b0;
         cycles = 0;
         while (!halted && cycles < 200) begin
            bus.if_ready = $urandom_range(0, 1) == 1;
            if (bus.if_valid) begin
               if (exp_pc.size() == 0) begin
                  n_cmp++; n_err++; $display("FAIL rnd%0d_extra: unexpected pc %h", it, bus.if_pc);
               end else begin
                  n_cmp++; if (bus.if_pc !== exp_pc[0] || bus.if_instr !== exp_ins[0]) begin
                     n_err++; $display("FAIL rnd%0d_data: pc %h instr %h want %h %h", it, bus.if_pc, bus.if_instr, exp_pc[0], exp_ins[0]);
                  end
                  if (bus.if_ready) begin
                     void'(exp_pc.pop_front());
                     void'(exp_ins.pop_front());
                  end
               end
            end
            tick();
            cycles++;
         end
         n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL rnd%0d_timeout: halted %b after %0d cycles want 1", it, halted, cycles); end
         n_cmp++; if (exp_pc.size() != 0 || instr_count !== 16'(len)) begin
            n_err++; $display("FAIL rnd%0d_count: count %0d left %0d want %0d 0", it, instr_count, exp_pc.size(), len);
         end
         run = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_step();
      test_stall();
      test_redirect();
      test_wrap();
      test_async_reset_and_halt_exit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
